// File: rtl/alu_job_arbiter.sv
// Round-robin job scheduler sharing one add/subtract engine between NREQ requesters.
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   req_valid     per-requester job pending
//   req_op        per-requester op (0 add, 1 subtract)
//   req_a, req_b  per-requester operands, requester i at [i*DW +: DW]
//   req_ready     one-hot accept pulse, combinational in the accept cycle
//   rsp_valid     one-hot one-cycle response strobe to the originating requester
//   rsp_result    shared result, meaningful only with rsp_valid
//   rsp_err       response qualifier: 1 = engine timeout, result forced to 0
//   busy          high whenever a job is in flight
//   grant_id      index of the job in flight, holds its last value when idle
//   eng_start     engine start level
//   eng_op_sel    engine op select
//   eng_a, eng_b  engine operands, held for the whole job
//   eng_result    engine result
//   eng_done      engine done level
module alu_job_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_op,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_result,
    output logic               rsp_err,
    output logic               busy,
    output logic [GW-1:0]      grant_id,
    output logic               eng_start,
    output logic               eng_op_sel,
    output logic [DW-1:0]      eng_a,
    output logic [DW-1:0]      eng_b,
    input  logic [DW-1:0]      eng_result,
    input  logic               eng_done
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StRelease, StResp} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic            op_q, op_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   result_q, result_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            grant_found;
    logic [GW-1:0]   grant_idx;
    logic [GW-1:0]   cand;
    logic [NREQ-1:0] ready_raw;

    // First set request searching upward from the slot after the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = GW'((32'(last_grant_q) + 32'd1 + i) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        ready_raw    = '0;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    ready_raw[grant_idx] = 1'b1;
                    op_d         = req_op[grant_idx];
                    a_d          = req_a[32'(grant_idx) * DW +: DW];
                    b_d          = req_b[32'(grant_idx) * DW +: DW];
                    grant_id_d   = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = '0;
                    err_d        = 1'b0;
                    result_d     = '0;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                // Done wins over timeout when both hold in the same cycle.
                if (eng_done) begin
                    result_d = eng_result;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRelease;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = StRelease;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                if (!eng_done) begin
                    state_d = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Done stuck high for TIMEOUT release cycles.
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= GW'(NREQ - 1);
            grant_id_q   <= '0;
            op_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    // The accept pulse is combinational, so it is masked while reset is held.
    assign req_ready  = rst ? '0 : ready_raw;
    assign busy       = (state_q != StIdle);
    assign eng_start  = (state_q == StIssue);
    assign eng_op_sel = op_q;
    assign eng_a      = a_q;
    assign eng_b      = b_q;
    assign grant_id   = grant_id_q;
    assign rsp_valid  = (state_q == StResp) ? ({{(NREQ - 1){1'b0}}, 1'b1} << grant_id_q) : '0;
    assign rsp_result = (state_q == StResp) ? result_q : '0;
    assign rsp_err    = (state_q == StResp) ? err_q : 1'b0;

endmodule

// File: tb/tb_alu_job_arbiter.sv
module tb_alu_job_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_op = '0;
    logic [NREQ*DW-1:0] req_a = '0;
    logic [NREQ*DW-1:0] req_b = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_result;
    logic               rsp_err;
    logic               busy;
    logic [1:0]         grant_id;
    logic               eng_start;
    logic               eng_op_sel;
    logic [DW-1:0]      eng_a;
    logic [DW-1:0]      eng_b;
    logic [DW-1:0]      eng_result = '0;
    logic               eng_done = 1'b0;

    alu_job_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .grant_id   (grant_id),
        .eng_start  (eng_start),
        .eng_op_sel (eng_op_sel),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_result (eng_result),
        .eng_done   (eng_done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Requester state as driven onto the ports.
    logic [NREQ-1:0] rv = '0;
    logic [NREQ-1:0] rop = '0;
    logic [DW-1:0]   ra [NREQ];
    logic [DW-1:0]   rb [NREQ];
    bit auto_req = 0;
    bit sticky   = 0;
    bit rst_level = 1;

    // Job-level reference model.
    bit          in_flight = 0;
    int          last_grant = NREQ - 1;
    int          issue_end, rsp_cyc;
    int          done_lo = -1, done_hi = -1;
    logic [DW-1:0] exp_res;
    bit          exp_err;
    logic        exp_op = 1'b0;
    logic [DW-1:0] exp_a = '0, exp_b = '0;
    int          exp_gid = 0;
    int          force_k = 3, force_h = 4;
    int          gq[$];

    // Observations of the DUT used by the literal checks.
    bit          got_rsp = 0;
    int          dut_acc_cyc = 0, rsp_cyc_obs = 0;
    logic [DW-1:0] rsp_res_obs;
    logic        rsp_err_obs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int rr_pick();
        for (int i = 1; i <= NREQ; i++) begin
            int j;
            j = (last_grant + i) % NREQ;
            if (rv[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive();
        req_valid = rv;
        req_op    = rop;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DW +: DW] = ra[i];
            req_b[i*DW +: DW] = rb[i];
        end
        eng_done   = (done_lo >= 0) && (cyc >= done_lo) && (cyc < done_hi);
        eng_result = eng_op_sel ? (eng_a - eng_b) : (eng_a + eng_b);
    endtask

    task automatic check_cycle();
        logic [NREQ-1:0] e_ready, e_rsp;
        int g;
        e_ready = '0;
        e_rsp   = '0;
        if (!rst && !in_flight) begin
            g = rr_pick();
            if (g >= 0) e_ready[g] = 1'b1;
        end
        if (!rst && in_flight && cyc == rsp_cyc) e_rsp[exp_gid] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(!rst && in_flight));
        chk("eng_start", 32'(eng_start), 32'(!rst && in_flight && cyc <= issue_end));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        if (e_rsp != 0) begin
            chk("rsp_result", 32'(rsp_result), 32'(exp_res));
            chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        end
        chk("grant_id", 32'(grant_id), 32'(exp_gid));
        chk("eng_op_sel", 32'(eng_op_sel), 32'(exp_op));
        chk("eng_a", 32'(eng_a), 32'(exp_a));
        chk("eng_b", 32'(eng_b), 32'(exp_b));
        if (req_ready != 0) dut_acc_cyc = cyc;
        if (rsp_valid != 0) begin
            got_rsp     = 1;
            rsp_cyc_obs = cyc;
            rsp_res_obs = rsp_result;
            rsp_err_obs = rsp_err;
        end
    endtask

    task automatic pick_kh(output int k, output int h);
        int r;
        if (force_k != -2) begin
            k = force_k;
            h = force_h;
        end else begin
            r = int'($urandom_range(9));
            k = (r == 0) ? -1 : (r == 1) ? TIMEOUT : int'($urandom_range(6));
            r = int'($urandom_range(9));
            h = (r == 0) ? TIMEOUT + 1 : (r == 1) ? TIMEOUT : int'($urandom_range(5, 1));
        end
    endtask

    // Engine done is high for cycles [T+1+k, T+1+k+h); k = -1 means never.
    task automatic accept(input int g);
        int k, h;
        pick_kh(k, h);
        exp_op = rop[g];
        exp_a  = ra[g];
        exp_b  = rb[g];
        exp_gid = g;
        last_grant = g;
        gq.push_back(g);
        in_flight = 1;
        if (k >= 0) begin
            done_lo   = cyc + 1 + k;
            done_hi   = cyc + 1 + k + h;
            issue_end = cyc + 1 + k;
            if (h - 1 >= TIMEOUT) begin
                rsp_cyc = cyc + 2 + k + TIMEOUT;
                exp_err = 1;
                exp_res = '0;
            end else begin
                rsp_cyc = cyc + 2 + k + h;
                exp_err = 0;
                exp_res = exp_op ? (exp_a - exp_b) : (exp_a + exp_b);
            end
        end else begin
            done_lo   = -1;
            issue_end = cyc + 1 + TIMEOUT;
            rsp_cyc   = cyc + TIMEOUT + 3;
            exp_err   = 1;
            exp_res   = '0;
        end
    endtask

    task automatic advance();
        int g;
        g = -1;
        if (rst) return;
        if (in_flight) begin
            if (cyc == rsp_cyc) in_flight = 0;
        end else begin
            g = rr_pick();
            if (g >= 0) accept(g);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (auto_req) begin
                if (rv[i] && i == g) begin
                    rv[i] = $urandom_range(1) == 1;
                    rop[i] = 1'($urandom_range(1));
                    ra[i] = DW'($urandom);
                    rb[i] = DW'($urandom);
                end else if (rv[i]) begin
                    if ($urandom_range(15) == 0) rv[i] = 1'b0;
                end else begin
                    rop[i] = 1'($urandom_range(1));
                    ra[i] = DW'($urandom);
                    rb[i] = DW'($urandom);
                    rv[i] = $urandom_range(3) == 0;
                end
            end else if (i == g && !sticky) begin
                rv[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        rst = rst_level;
        drive();
        @(negedge clk);
        check_cycle();
        advance();
    endtask

    task automatic wait_rsp(input string name, input int max);
        got_rsp = 0;
        for (int n = 0; n < max && !got_rsp; n++) step();
        chk(name, 32'(got_rsp), 32'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && in_flight; n++) step();
        chk("wait_idle", 32'(in_flight), 32'd0);
    endtask

    task automatic set_req(input int i, input logic op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        rv[i] = 1'b1;
        rop[i] = op;
        ra[i] = a;
        rb[i] = b;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_eng_start"}, 32'(eng_start), 32'd0);
        chk({tag, "_eng_op_sel"}, 32'(eng_op_sel), 32'd0);
        chk({tag, "_eng_a"}, 32'(eng_a), 32'd0);
        chk({tag, "_eng_b"}, 32'(eng_b), 32'd0);
    endtask

    initial begin
        int n0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = DW'(8'h11 * (i + 1));
            rb[i] = DW'(8'h01 * (i + 1));
        end
        // Reset with every request pending: no accept may leak out.
        rv = '1;
        drive();
        #1;
        check_all_zero("reset");
        step();
        step();

        // Round-robin from reset with all requesters continuously valid.
        gq.delete();
        sticky = 1;
        rst_level = 0;
        for (int n = 0; n < 200 && gq.size() < 6; n++) step();
        sticky = 0;
        rv = '0;
        wait_idle();
        chk("rr_count", 32'(gq.size()), 32'd6);
        if (gq.size() >= 6) begin
            chk("rr_g0", 32'(gq[0]), 32'd0);
            chk("rr_g1", 32'(gq[1]), 32'd1);
            chk("rr_g2", 32'(gq[2]), 32'd2);
            chk("rr_g3", 32'(gq[3]), 32'd3);
            chk("rr_g4", 32'(gq[4]), 32'd0);
            chk("rr_g5_req1_again", 32'(gq[5]), 32'd1);
        end

        // Single add job with the team engine timing.
        step();
        set_req(0, 1'b0, 8'h25, 8'h13);
        wait_rsp("single_rsp", 40);
        chk("single_latency", 32'(rsp_cyc_obs - dut_acc_cyc), 32'd9);
        chk("single_result", 32'(rsp_res_obs), 32'h38);
        chk("single_err", 32'(rsp_err_obs), 32'd0);

        // Subtract with wrap; requester payload changes while the job runs.
        step();
        set_req(2, 1'b1, 8'h03, 8'h05);
        for (int n = 0; n < 10 && !in_flight; n++) step();
        ra[2] = 8'hAA;
        rb[2] = 8'h55;
        wait_rsp("sub_rsp", 40);
        chk("sub_result", 32'(rsp_res_obs), 32'hFE);
        chk("sub_err", 32'(rsp_err_obs), 32'd0);

        step();
        set_req(1, 1'b0, 8'hF0, 8'h20);
        wait_rsp("wrap_rsp", 40);
        chk("wrap_result", 32'(rsp_res_obs), 32'h10);

        // Engine never answers.
        step();
        force_k = -1;
        set_req(3, 1'b0, 8'h12, 8'h34);
        wait_rsp("tmo_rsp", 60);
        chk("tmo_latency", 32'(rsp_cyc_obs - dut_acc_cyc), 32'(TIMEOUT + 3));
        chk("tmo_err", 32'(rsp_err_obs), 32'd1);
        chk("tmo_result", 32'(rsp_res_obs), 32'd0);
        force_k = 3;
        step();
        set_req(0, 1'b0, 8'h01, 8'h02);
        wait_rsp("after_tmo_rsp", 40);
        chk("after_tmo_result", 32'(rsp_res_obs), 32'h03);
        chk("after_tmo_err", 32'(rsp_err_obs), 32'd0);

        // Randomized traffic and engine timing, including both timeout boundaries.
        force_k = -2;
        auto_req = 1;
        for (int n = 0; n < 3000; n++) step();
        auto_req = 0;
        rv = '0;
        wait_idle();
        step();

        // Reset in the middle of a job.
        force_k = -1;
        set_req(2, 1'b1, 8'h40, 8'h01);
        for (int n = 0; n < 10 && !in_flight; n++) step();
        step();
        step();
        rv = '1;
        @(posedge clk);
        cyc++;
        #1;
        drive();
        rst = 1'b1;
        rst_level = 1;
        #1;
        check_all_zero("midrst");
        in_flight = 0;
        last_grant = NREQ - 1;
        exp_op = 1'b0;
        exp_a = '0;
        exp_b = '0;
        exp_gid = 0;
        done_lo = -1;
        @(negedge clk);
        check_cycle();
        advance();
        step();
        step();
        force_k = 3;
        rst_level = 0;
        n0 = gq.size();
        got_rsp = 0;
        for (int n = 0; n < 10 && gq.size() == n0; n++) step();
        rv = '0;
        chk("post_rst_granted", 32'(gq.size() > n0), 32'd1);
        if (gq.size() > n0) chk("post_rst_grant0", 32'(gq[n0]), 32'd0);
        wait_rsp("post_rst_rsp", 40);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
